// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encodings and elaboration-time helpers for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK_ALL = 2'd0,
        MODE_CHASE     = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_COUNT     = 2'd3
    } mode_t;

    function automatic int calc_div(input int clk_freq, input int step_hz);
        return clk_freq / step_hz;
    endfunction

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control inputs and LED/tick outputs of the pattern generator; no flow control.
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
);
    logic [1:0]          mode;
    logic                enable;
    logic [PWM_BITS-1:0] brightness;
    logic [NUM_LEDS-1:0] LED;
    logic                step_tick;

    modport master (output mode, enable, brightness, input LED, step_tick);
    modport slave  (input mode, enable, brightness, output LED, step_tick);
endinterface

// File: rtl/led_pattern_gen_tick_divider.sv
// Divide-by-DIV strobe: one-cycle registered tick every DIV cycles, first on cycle DIV.
// Free-running, no backpressure.
module tick_divider
    import led_pattern_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);
    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("tick_divider: DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED animator with global PWM brightness; LED follows a pattern step one cycle after step_tick.
// Inputs sampled every cycle, outputs free-running; no backpressure.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CLK_FREQ = 12000000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    led_pattern_gen_if.slave bus
);
    localparam int DIV = calc_div(CLK_FREQ, STEP_HZ);

    typedef logic [NUM_LEDS-1:0] pat_t;

    function automatic pat_t init_pat(input mode_t m);
        case (m)
            MODE_CHASE, MODE_BOUNCE: return pat_t'(1);
            default:                 return '0;
        endcase
    endfunction

    logic                tick;
    mode_t               mode_q, mode_d, req_mode;
    pat_t                pattern_q, pattern_d;
    logic                dir_up_q, dir_up_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    pat_t                led_q, led_d;
    logic                bounce_up, bounce_dir, pwm_on;
    pat_t                bounce_nxt, chase_nxt;

    tick_divider #(.DIV(DIV)) u_div (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q    <= MODE_BLINK_ALL;
            pattern_q <= '0;
            dir_up_q  <= 1'b1;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            dir_up_q  <= dir_up_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    always_comb begin
        req_mode   = mode_t'(bus.mode);
        chase_nxt  = (pattern_q << 1) | (pattern_q >> (NUM_LEDS - 1));
        // Bounce turns around on the endpoint itself so the endpoint is never shown twice.
        bounce_up  = dir_up_q ? ~pattern_q[NUM_LEDS-1] : pattern_q[0];
        bounce_nxt = (NUM_LEDS == 1) ? pattern_q
                   : (bounce_up ? (pattern_q << 1) : (pattern_q >> 1));
        bounce_dir = bounce_nxt[NUM_LEDS-1] ? 1'b0 : (bounce_nxt[0] ? 1'b1 : bounce_up);

        mode_d    = mode_q;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;
        if (tick) begin
            if (req_mode != mode_q) begin
                mode_d    = req_mode;
                pattern_d = init_pat(req_mode);
                dir_up_d  = 1'b1;
            end else if (bus.enable) begin
                case (mode_q)
                    MODE_BLINK_ALL: pattern_d = ~pattern_q;
                    MODE_CHASE:     pattern_d = chase_nxt;
                    MODE_BOUNCE: begin
                        pattern_d = bounce_nxt;
                        dir_up_d  = bounce_dir;
                    end
                    default:        pattern_d = pattern_q + pat_t'(1);
                endcase
            end
        end
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = (&bus.brightness) | (pwm_cnt_q < bus.brightness);
        led_d     = pattern_d & {NUM_LEDS{pwm_on}};
    end

    assign bus.LED       = led_q;
    assign bus.step_tick = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: reset/tick timing, table of per-tick LED expectations, PWM and reset corners.
module tb_led_pattern_gen;
    localparam int N   = 4;
    localparam int PB  = 2;
    localparam int DIV = 10;

    typedef struct {
        logic [1:0]   mode;
        logic         en;
        logic [N-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t vecs[$];
    logic [N-1:0] sb[$];

    always #5 clk = ~clk;

    led_pattern_gen_if #(.NUM_LEDS(N), .PWM_BITS(PB)) bus ();

    led_pattern_gen #(
        .NUM_LEDS (N),
        .CLK_FREQ (100),
        .STEP_HZ  (10),
        .PWM_BITS (PB)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic add_vec(input logic [1:0] m, input logic e, input logic [N-1:0] x);
        vec_t v;
        v.mode = m;
        v.en   = e;
        v.exp  = x;
        vecs.push_back(v);
    endtask

    task automatic wait_tick(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (bus.step_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: no step_tick within %0d cycles", nm, 3 * DIV);
        end
    endtask

    // Counts cycles from a reset release taken on a negedge: tick only on the 10th, LED=1111 on the 11th.
    task automatic check_restart(input string nm);
        int early;
        early = 0;
        for (int k = 1; k < DIV; k++) begin
            @(negedge clk);
            if (bus.step_tick !== 1'b0) early++;
        end
        chk({nm, "_early_tick"}, early, 0);
        @(negedge clk);
        chk({nm, "_tick_at_div"}, bus.step_tick, 1);
        chk({nm, "_led_at_div"}, bus.LED, 0);
        @(negedge clk);
        chk({nm, "_blink_on"}, bus.LED, 4'hF);
        chk({nm, "_tick_pulse_len"}, bus.step_tick, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int on_cnt, bad;
        logic [N-1:0] exp;

        bus.mode       = 2'd0;
        bus.enable     = 1'b1;
        bus.brightness = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_led", bus.LED, 0);
        chk("rst_tick", bus.step_tick, 0);

        rst = 1'b0;
        check_restart("start");
        repeat (DIV - 1) @(negedge clk);
        chk("second_tick", bus.step_tick, 1);
        @(negedge clk);
        chk("blink_off", bus.LED, 0);

        // CHASE: load then rotate with wrap
        add_vec(2'd1, 1'b1, 4'b0001);
        add_vec(2'd1, 1'b1, 4'b0010);
        add_vec(2'd1, 1'b1, 4'b0100);
        add_vec(2'd1, 1'b1, 4'b1000);
        add_vec(2'd1, 1'b1, 4'b0001);
        // BOUNCE: load then no repeated endpoints
        add_vec(2'd2, 1'b1, 4'b0001);
        add_vec(2'd2, 1'b1, 4'b0010);
        add_vec(2'd2, 1'b1, 4'b0100);
        add_vec(2'd2, 1'b1, 4'b1000);
        add_vec(2'd2, 1'b1, 4'b0100);
        add_vec(2'd2, 1'b1, 4'b0010);
        add_vec(2'd2, 1'b1, 4'b0001);
        add_vec(2'd2, 1'b1, 4'b0010);
        add_vec(2'd2, 1'b1, 4'b0100);
        // COUNT: load to zero, full wrap, then up to 0101 and hold while disabled
        add_vec(2'd3, 1'b1, 4'b0000);
        for (int i = 1; i <= 16; i++) add_vec(2'd3, 1'b1, N'(i));
        for (int i = 1; i <= 5; i++) add_vec(2'd3, 1'b1, N'(i));
        for (int i = 0; i < 3; i++) add_vec(2'd3, 1'b0, 4'b0101);

        foreach (vecs[i]) begin
            bus.mode   = vecs[i].mode;
            bus.enable = vecs[i].en;
            sb.push_back(vecs[i].exp);
            wait_tick($sformatf("vec%0d", i));
            @(negedge clk);
            exp = sb.pop_front();
            chk($sformatf("vec%0d", i), bus.LED, exp);
        end

        // PWM at 1/4 duty on held pattern 0101
        bus.brightness = 2'd1;
        @(negedge clk);
        on_cnt = 0;
        bad    = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.LED === 4'b0101) on_cnt++;
            else if (bus.LED !== 4'b0000) bad++;
        end
        chk("pwm_quarter_on", on_cnt, 2);
        chk("pwm_quarter_bad", bad, 0);

        bus.brightness = 2'd0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.LED !== 4'b0000) bad++;
        end
        chk("pwm_zero", bad, 0);

        bus.brightness = 2'd3;
        @(negedge clk);
        chk("pwm_full", bus.LED, 4'b0101);

        // Mode change while disabled still loads; further ticks hold
        bus.mode   = 2'd1;
        bus.enable = 1'b0;
        wait_tick("load_disabled");
        @(negedge clk);
        chk("load_disabled", bus.LED, 4'b0001);
        wait_tick("hold_disabled");
        @(negedge clk);
        chk("hold_disabled", bus.LED, 4'b0001);

        // Asynchronous reset mid-period
        repeat (3) @(negedge clk);
        chk("pre_rst_led", bus.LED, 4'b0001);
        rst = 1'b1;
        #1;
        chk("async_rst_led", bus.LED, 0);
        chk("async_rst_tick", bus.step_tick, 0);
        bus.mode   = 2'd0;
        bus.enable = 1'b1;
        @(negedge clk);
        chk("rst_hold_led", bus.LED, 0);
        rst = 1'b0;
        check_restart("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED pattern generator for board bring-up and status display. It extends the fixed per-LED one-second blinker with four selectable animation modes, a configurable step rate and global PWM brightness. A prescaler produces a step tick. A pattern engine advances a NUM_LEDS-wide pattern on each tick. A PWM stage gates the pattern onto the registered LED outputs.

Parameters:
NUM_LEDS, 4, number of LED channels (>=1)
CLK_FREQ, 12000000, input clock frequency in Hz
STEP_HZ, 4, pattern step rate in Hz; DIV = CLK_FREQ/STEP_HZ, DIV>=2 enforced by elaboration check
PWM_BITS, 8, brightness resolution in bits

Ports:
CLK  input  1  system clock; single clock domain
RST  input  1  asynchronous, active-high reset
mode  input  2  requested mode: 0 BLINK_ALL, 1 CHASE, 2 BOUNCE, 3 COUNT
enable  input  1  1 = pattern advances on ticks; 0 = pattern frozen
brightness  input  PWM_BITS  global duty; 0 = off, all-ones = full on
LED  output  NUM_LEDS  registered, PWM-gated pattern
step_tick  output  1  one-cycle pulse each step period, for chaining/debug

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous and active-high.
- Reset values: prescaler=0, pwm_cnt=0, active_mode=BLINK_ALL, pattern=0, dir=up, LED=0, step_tick=0.
- Prescaler: counts 0..DIV-1 and wraps to 0. step_tick=1 for exactly the cycle after count==DIV-1, i.e. once every DIV cycles. The first tick after reset release occurs on cycle DIV. The prescaler runs regardless of enable.
- Mode load: on a tick where mode != active_mode, set active_mode<=mode and pattern<=init(mode), with dir=up. No step is taken on that tick, and enable is ignored for the load.
- init values: BLINK_ALL=all 0; CHASE=bit0 set; BOUNCE=bit0 set; COUNT=0.
- Step: on a tick with enable=1 and no mode load, advance per active_mode:
  - BLINK_ALL: pattern<=~pattern.
  - CHASE: rotate left by 1; MSB wraps to bit0.
  - BOUNCE: one-hot moves toward the MSB while dir=up. On reaching the MSB, dir flips and the next step moves down. On reaching bit0, dir flips to up. Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010,… with no repeated endpoint. For NUM_LEDS=1 the pattern stays 1.
  - COUNT: pattern<=pattern+1 modulo 2^NUM_LEDS; all-ones wraps to 0.
- enable=0: pattern and dir hold; LEDs still show the held pattern under PWM.
- PWM: pwm_cnt is a free-running PWM_BITS counter. on = (brightness==all-ones) | (pwm_cnt < brightness). Duty = brightness/2^PWM_BITS, except all-ones gives 100%.
- Output: LED <= pattern & {NUM_LEDS{on}}, registered. LED reflects a pattern change one cycle after the step_tick cycle.
- Simultaneous mode change and disable: the load still occurs (see Mode load).
- Reset asserted mid-pattern: all state clears immediately (asynchronous). After release, operation restarts in BLINK_ALL with a full DIV wait.

Decomposition:
- Package led_pattern_pkg holds:
  - mode encodings MODE_BLINK_ALL/MODE_CHASE/MODE_BOUNCE/MODE_COUNT;
  - the DIV computation function;
  - clog2 helper for the prescaler width.
- Sub-module tick_divider (params DIV; ports CLK, RST, tick) is natural and reusable by other timing blocks.
- The pattern engine and PWM stay in the top module.

Test Plan:
- Params NUM_LEDS=4, CLK_FREQ=100, STEP_HZ=10 (DIV=10), PWM_BITS=2, brightness=3.
  1. Reset release -> LED=0000, first step_tick at cycle 10; BLINK_ALL gives LED=1111 at cycle 11 and 0000 at cycle 21.
  2. mode=1 -> first tick loads 0001 with no step; subsequent ticks give 0010,0100,1000,0001 (wrap).
  3. mode=2 over 8 ticks after load -> 0010,0100,1000,0100,0010,0001,0010,0100.
  4. mode=3 from load, 16 steps -> counts 0001..1111 then 0000.
  5. brightness=1 in COUNT with pattern 0101 -> LED=0101 one cycle in four, else 0000; brightness=0 -> LED stays 0000.
  6. enable=0 for 3 ticks -> pattern held. Then assert RST mid-period for 1 cycle -> LED=0 immediately, step_tick next seen 10 cycles after release, active_mode=BLINK_ALL.
